matrix_apb_slave: RTL and testbench

APB3 slave front-end for the matrix multiplier accelerator. It converts APB transfers into single-cycle register-file accesses: write enable, 9-bit local address, write data and byte strobes out; read data back. It sits directly upstream of the matrix register file. It decodes and rejects illegal accesses and stalls writes while a multiplication is in flight, with a bounded wait.

---
 rtl/matrix_pkg.sv | 21 ++
 rtl/matrix_addr_decode.sv | 39 +++
 rtl/matrix_apb_slave.sv | 147 ++++++++++++++
 tb/tb_matrix_apb_slave.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/matrix_pkg.sv
// Shared constants and types for the matrix multiplier APB front-end.
package matrix_pkg;

  localparam int LOC_ADDR_WIDTH = 9;

  localparam logic [4:0] OFF_CTRL  = 5'd0;
  localparam logic [4:0] OFF_MATA  = 5'd4;
  localparam logic [4:0] OFF_MATB  = 5'd8;
  localparam logic [4:0] OFF_FLAGS = 5'd12;
  localparam logic [4:0] OFF_SP0   = 5'd16;
  localparam logic [4:0] OFF_SP1   = 5'd20;
  localparam logic [4:0] OFF_SP2   = 5'd24;
  localparam logic [4:0] OFF_SP3   = 5'd28;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_WAIT   = 2'd2
  } apb_state_e;

endpackage

// File: rtl/matrix_addr_decode.sv
// Combinational legality check of an APB access to the matrix register file.
module matrix_addr_decode
  import matrix_pkg::*;
#(
  parameter int ADDR_WIDTH  = 16,
  parameter int SP_NTARGETS = 4
) (
  input  logic [ADDR_WIDTH-1:0] i_addr,
  input  logic                  i_write,
  output logic                  o_err
);

  logic [4:0] w_off;
  logic       w_misaligned;
  logic       w_out_of_range;
  logic       w_sp_missing;
  logic       w_ro_write;

  assign w_off          = i_addr[4:0];
  assign w_misaligned   = (i_addr[1:0] != 2'b00);
  assign w_out_of_range = (i_addr[ADDR_WIDTH-1:LOC_ADDR_WIDTH] != '0);
  // Flags and all scratchpads are read-only from the bus.
  assign w_ro_write     = i_write && (w_off >= OFF_FLAGS) && (w_off <= OFF_SP3);

  // Flag scratchpad offsets that are not built in this configuration.
  always_comb begin
    w_sp_missing = 1'b0;
    if ((w_off == OFF_SP1) && (SP_NTARGETS < 32'sd2)) begin
      w_sp_missing = 1'b1;
    end else if (((w_off == OFF_SP2) || (w_off == OFF_SP3)) && (SP_NTARGETS < 32'sd4)) begin
      w_sp_missing = 1'b1;
    end else begin
      w_sp_missing = 1'b0;
    end
  end

  assign o_err = w_misaligned | w_out_of_range | w_sp_missing | w_ro_write;

endmodule

// File: rtl/matrix_apb_slave.sv
// APB3 slave turning bus transfers into single-cycle register-file accesses,
// stalling writes while the multiplier is busy (bounded by WAIT_MAX).
module matrix_apb_slave
  import matrix_pkg::*;
#(
  parameter int  BUS_WIDTH   = 32,
  parameter int  DATA_WIDTH  = 8,
  parameter int  ADDR_WIDTH  = 16,
  parameter int  SP_NTARGETS = 4,
  parameter int  WAIT_MAX    = 15,
  localparam int MAX_DIM     = BUS_WIDTH / DATA_WIDTH
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      psel_i,
  input  logic                      penable_i,
  input  logic                      pwrite_i,
  input  logic [ADDR_WIDTH-1:0]     paddr_i,
  input  logic [BUS_WIDTH-1:0]      pwdata_i,
  input  logic [MAX_DIM-1:0]        pstrb_i,
  output logic [BUS_WIDTH-1:0]      prdata_o,
  output logic                      pready_o,
  output logic                      pslverr_o,
  input  logic                      busy_i,
  output logic                      rf_we_o,
  output logic [LOC_ADDR_WIDTH-1:0] rf_addr_o,
  output logic [BUS_WIDTH-1:0]      rf_wdata_o,
  output logic [MAX_DIM-1:0]        rf_strb_o,
  input  logic [BUS_WIDTH-1:0]      rf_rdata_i
);

  localparam int CNT_W = $clog2(WAIT_MAX + 1);

  apb_state_e                r_state;
  logic [LOC_ADDR_WIDTH-1:0] r_addr;
  logic                      r_write;
  logic [BUS_WIDTH-1:0]      r_wdata;
  logic [MAX_DIM-1:0]        r_strb;
  logic                      r_err;
  logic [CNT_W-1:0]          r_cnt;

  logic             w_setup;
  logic             w_xfer;
  logic             w_dec_err;
  logic             w_timeout;
  logic [CNT_W-1:0] w_cnt_inc;

  matrix_addr_decode #(
    .ADDR_WIDTH  (ADDR_WIDTH),
    .SP_NTARGETS (SP_NTARGETS)
  ) u_addr_decode (
    .i_addr  (paddr_i),
    .i_write (pwrite_i),
    .o_err   (w_dec_err)
  );

  assign w_setup   = psel_i & ~penable_i;
  assign w_xfer    = psel_i & penable_i;
  assign w_cnt_inc = r_cnt + CNT_W'(1);
  // busy_i low takes precedence over the timeout, so a write in the last cycle still lands.
  assign w_timeout = busy_i && (w_cnt_inc == CNT_W'(WAIT_MAX));

  // Transfer FSM and request latches.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= ST_IDLE;
      r_addr  <= '0;
      r_write <= 1'b0;
      r_wdata <= '0;
      r_strb  <= '0;
      r_err   <= 1'b0;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_setup) begin
            r_addr  <= paddr_i[LOC_ADDR_WIDTH-1:0];
            r_write <= pwrite_i;
            r_wdata <= pwdata_i;
            r_strb  <= pstrb_i;
            r_err   <= w_dec_err;
            r_state <= ST_ACCESS;
          end
        end
        ST_ACCESS: begin
          if (w_xfer && !r_err && r_write && busy_i) begin
            r_cnt   <= '0;
            r_state <= ST_WAIT;
          end else begin
            r_state <= ST_IDLE;
          end
        end
        ST_WAIT: begin
          if (!w_xfer || !busy_i || w_timeout) begin
            r_state <= ST_IDLE;
          end else begin
            r_cnt <= w_cnt_inc;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Bus response and register-file strobe decode.
  always_comb begin
    pready_o  = 1'b0;
    pslverr_o = 1'b0;
    rf_we_o   = 1'b0;
    prdata_o  = '0;
    case (r_state)
      ST_ACCESS: begin
        if (!w_xfer) begin
          pready_o = 1'b0;
        end else if (r_err) begin
          pready_o  = 1'b1;
          pslverr_o = 1'b1;
        end else if (r_write && busy_i) begin
          pready_o = 1'b0;
        end else begin
          pready_o = 1'b1;
          rf_we_o  = r_write;
          prdata_o = r_write ? '0 : rf_rdata_i;
        end
      end
      ST_WAIT: begin
        if (!w_xfer) begin
          pready_o = 1'b0;
        end else if (!busy_i) begin
          pready_o = 1'b1;
          rf_we_o  = 1'b1;
        end else if (w_timeout) begin
          pready_o  = 1'b1;
          pslverr_o = 1'b1;
        end else begin
          pready_o = 1'b0;
        end
      end
      default: pready_o = 1'b0;
    endcase
  end

  assign rf_addr_o  = r_addr;
  assign rf_wdata_o = r_wdata;
  assign rf_strb_o  = r_strb;

endmodule

// File: tb/tb_matrix_apb_slave.sv
// Directed self-checking bench for matrix_apb_slave (SP_NTARGETS=2, WAIT_MAX=15).
module tb_matrix_apb_slave;

  logic        clk_i      = 1'b0;
  logic        rst_ni     = 1'b0;
  logic        psel_i     = 1'b0;
  logic        penable_i  = 1'b0;
  logic        pwrite_i   = 1'b0;
  logic        busy_i     = 1'b0;
  logic [15:0] paddr_i    = 16'h0000;
  logic [31:0] pwdata_i   = 32'h0;
  logic [3:0]  pstrb_i    = 4'h0;
  logic [31:0] rf_rdata_i = 32'hDEADBEEF;
  logic [31:0] prdata_o;
  logic [31:0] rf_wdata_o;
  logic [3:0]  rf_strb_o;
  logic [8:0]  rf_addr_o;
  logic        pready_o;
  logic        pslverr_o;
  logic        rf_we_o;

  int n_checks = 0;
  int n_errors = 0;

  matrix_apb_slave #(
    .BUS_WIDTH   (32),
    .DATA_WIDTH  (8),
    .ADDR_WIDTH  (16),
    .SP_NTARGETS (2),
    .WAIT_MAX    (15)
  ) dut (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .psel_i     (psel_i),
    .penable_i  (penable_i),
    .pwrite_i   (pwrite_i),
    .paddr_i    (paddr_i),
    .pwdata_i   (pwdata_i),
    .pstrb_i    (pstrb_i),
    .prdata_o   (prdata_o),
    .pready_o   (pready_o),
    .pslverr_o  (pslverr_o),
    .busy_i     (busy_i),
    .rf_we_o    (rf_we_o),
    .rf_addr_o  (rf_addr_o),
    .rf_wdata_o (rf_wdata_o),
    .rf_strb_o  (rf_strb_o),
    .rf_rdata_i (rf_rdata_i)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, ".pready"},  32'(pready_o),  32'd0);
    check({tag, ".pslverr"}, 32'(pslverr_o), 32'd0);
    check({tag, ".rf_we"},   32'(rf_we_o),   32'd0);
    check({tag, ".prdata"},  prdata_o,       32'd0);
  endtask

  // One APB transfer starting on the next clock; busy_i is high for the
  // first busy_cycles cycles counted from the ACCESS cycle.
  task automatic xfer_check(input string tag, input logic wr, input logic [15:0] addr,
                            input logic [31:0] wdata, input logic [3:0] strb,
                            input int busy_cycles, input int exp_lat, input logic exp_err,
                            input int exp_we, input logic [31:0] exp_rdata);
    int          k;
    int          we_cnt;
    logic        done;
    logic        err;
    logic [31:0] rd;
    logic [8:0]  wa;
    logic [31:0] wd;
    logic [3:0]  ws;
    @(posedge clk_i); #1;
    psel_i = 1'b1; penable_i = 1'b0; pwrite_i = wr; paddr_i = addr;
    pwdata_i = wdata; pstrb_i = strb; busy_i = 1'b0;
    k = 0; we_cnt = 0; done = 1'b0; err = 1'b0; rd = 32'h0; wa = 9'h0; wd = 32'h0; ws = 4'h0;
    @(negedge clk_i);
    if (rf_we_o) we_cnt++;
    while (!done && k < 40) begin
      @(posedge clk_i); #1;
      penable_i = 1'b1;
      busy_i = (k < busy_cycles);
      @(negedge clk_i);
      if (rf_we_o) begin
        we_cnt++; wa = rf_addr_o; wd = rf_wdata_o; ws = rf_strb_o;
      end
      if (pready_o) begin
        done = 1'b1; err = pslverr_o; rd = prdata_o;
      end
      k++;
    end
    check({tag, ".done"},    32'(done),   32'd1);
    check({tag, ".latency"}, 32'(k + 1),  32'(exp_lat));
    check({tag, ".pslverr"}, 32'(err),    32'(exp_err));
    check({tag, ".we_cnt"},  32'(we_cnt), 32'(exp_we));
    check({tag, ".prdata"},  rd,          exp_rdata);
    if (exp_we != 0) begin
      check({tag, ".rf_addr"},  32'(wa), 32'(addr[8:0]));
      check({tag, ".rf_wdata"}, wd,      wdata);
      check({tag, ".rf_strb"},  32'(ws), 32'(strb));
    end
  endtask

  task automatic go_idle();
    @(posedge clk_i); #1;
    psel_i = 1'b0; penable_i = 1'b0; busy_i = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    repeat (2) @(negedge clk_i);
    check_all_zero("reset");
    check("reset.rf_addr",  32'(rf_addr_o), 32'd0);
    check("reset.rf_wdata", rf_wdata_o,     32'd0);
    check("reset.rf_strb",  32'(rf_strb_o), 32'd0);
    rst_ni = 1'b1;
    @(negedge clk_i);
    check_all_zero("post_reset");

    xfer_check("wr_mata",   1'b1, 16'h0004, 32'h04030201, 4'hF, 0,   2,  1'b0, 1, 32'h0);
    xfer_check("rd_sp0",    1'b0, 16'h0010, 32'h0,        4'h0, 0,   2,  1'b0, 0, 32'hDEADBEEF);
    xfer_check("wr_stall5", 1'b1, 16'h0000, 32'hCAFE0001, 4'h3, 5,   7,  1'b0, 1, 32'h0);
    xfer_check("wr_tmo",    1'b1, 16'h0008, 32'h12345678, 4'hF, 100, 17, 1'b1, 0, 32'h0);
    xfer_check("wr_edge15", 1'b1, 16'h0008, 32'h87654321, 4'h9, 15,  17, 1'b0, 1, 32'h0);
    xfer_check("rd_busy",   1'b0, 16'h0014, 32'h0,        4'h0, 3,   2,  1'b0, 0, 32'hDEADBEEF);
    xfer_check("rd_flags",  1'b0, 16'h000C, 32'h0,        4'h0, 0,   2,  1'b0, 0, 32'hDEADBEEF);
    xfer_check("err_wr_fl", 1'b1, 16'h000C, 32'hFFFFFFFF, 4'hF, 0,   2,  1'b1, 0, 32'h0);
    xfer_check("err_wr_sp", 1'b1, 16'h0010, 32'hFFFFFFFF, 4'hF, 0,   2,  1'b1, 0, 32'h0);
    xfer_check("err_sp2",   1'b0, 16'h0018, 32'h0,        4'h0, 0,   2,  1'b1, 0, 32'h0);
    xfer_check("err_sp3",   1'b0, 16'h001C, 32'h0,        4'h0, 0,   2,  1'b1, 0, 32'h0);
    xfer_check("err_align", 1'b0, 16'h0002, 32'h0,        4'h0, 0,   2,  1'b1, 0, 32'h0);
    xfer_check("err_range", 1'b0, 16'h0200, 32'h0,        4'h0, 0,   2,  1'b1, 0, 32'h0);
    xfer_check("b2b_wr",    1'b1, 16'h0104, 32'hA1B2C3D4, 4'h5, 0,   2,  1'b0, 1, 32'h0);
    xfer_check("b2b_rd",    1'b0, 16'h0108, 32'h0,        4'h0, 0,   2,  1'b0, 0, 32'hDEADBEEF);
    go_idle();
    @(negedge clk_i);
    check_all_zero("idle");

    // Stalled write abandoned by dropping psel during WAIT.
    @(posedge clk_i); #1;
    psel_i = 1'b1; penable_i = 1'b0; pwrite_i = 1'b1; paddr_i = 16'h0004;
    pwdata_i = 32'hA5A5A5A5; pstrb_i = 4'hF; busy_i = 1'b1;
    @(posedge clk_i); #1;
    penable_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_i);
      check("abort.stall_pready", 32'(pready_o), 32'd0);
      check("abort.stall_we",     32'(rf_we_o),  32'd0);
      @(posedge clk_i); #1;
    end
    psel_i = 1'b0; penable_i = 1'b0;
    @(negedge clk_i);
    check_all_zero("abort.drop");
    @(posedge clk_i); #1;
    busy_i = 1'b0;
    @(negedge clk_i);
    check_all_zero("abort.after");

    // Reset pulsed in the middle of a SETUP cycle.
    @(posedge clk_i); #1;
    psel_i = 1'b1; penable_i = 1'b0; pwrite_i = 1'b1; paddr_i = 16'h0008;
    pwdata_i = 32'h11223344; pstrb_i = 4'hF;
    #2 rst_ni = 1'b0;
    @(negedge clk_i);
    check_all_zero("rst_mid");
    check("rst_mid.rf_addr",  32'(rf_addr_o), 32'd0);
    check("rst_mid.rf_wdata", rf_wdata_o,     32'd0);
    check("rst_mid.rf_strb",  32'(rf_strb_o), 32'd0);
    @(posedge clk_i); #1;
    rst_ni = 1'b1; psel_i = 1'b0; penable_i = 1'b0;
    @(negedge clk_i);
    check_all_zero("rst_rel");
    xfer_check("post_rst", 1'b1, 16'h0008, 32'h55AA55AA, 4'hF, 0, 2, 1'b0, 1, 32'h0);
    go_idle();
    @(negedge clk_i);
    check_all_zero("final_idle");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
